// File: rtl/gf_inv_8_front.sv
// gf_inv_8_front: input stage of the pipelined GF(2^8) inverter used by the
// composite-field S-box. It splits a normal-basis byte into a = [7:4] and
// b = [3:0], then registers {a, b, c} where c = nu*(a^b)^2 ^ a*b. The next
// stage feeds c to gf_inv_4 and keeps a and b for its multiply.
//
// GF(2^4) normal basis: {B, B^2, B^4, B^8} with B^5 = 1, so the element
// 4'hF is the unit. Bit map: [3]=B, [2]=B^2, [1]=B^4, [0]=B^8=B^3. With this
// map, squaring is a rotate right by one bit. The scale constant is nu = B.
//
// Parameters:
//   REG_INPUT  1: byte register S1 ahead of the arithmetic (latency 2)
//              0: arithmetic works directly on in_data (latency 1)
// Optional feature:
//   GF_INV_8_FRONT_SKID_EN  one-entry input skid buffer. With it, in_ready
//                           is !skid_valid and has no path from out_ready.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous clear of every valid bit
//   in_valid/in_ready   input handshake, in_data = {a, b}
//   out_valid/out_ready output handshake for out_a, out_b, out_c
module gf_inv_8_front #(
  parameter int unsigned REG_INPUT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_a,
  output logic [3:0] out_b,
  output logic [3:0] out_c
);

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BYTE_W = 8;

  typedef struct packed {
    logic [NIB_W-1:0] a;
    logic [NIB_W-1:0] b;
    logic [NIB_W-1:0] c;
  } front_t;

  // nu * s^2 with nu = B. In exponent terms, s^2 moves B^e to B^(2e) and
  // nu moves it on to B^(2e+1). B^2 contributes B^5 = 1, the all-ones element.
  function automatic logic [NIB_W-1:0] gf_sq_scl_4(input logic [NIB_W-1:0] s);
    logic e1, e2, e3, e4;
    e1 = s[3]; e2 = s[2]; e4 = s[1]; e3 = s[0];
    return {e2, e3 ^ e2, e4 ^ e2, e1 ^ e2};
  endfunction

  // Normal-basis multiply. The product of B^i and B^j is B^((i+j) mod 5).
  // Term pairs whose exponents sum to 0 mod 5 give the unit, so z is added
  // to every coordinate.
  function automatic logic [NIB_W-1:0] gf_muls_4(input logic [NIB_W-1:0] x,
                                                  input logic [NIB_W-1:0] y);
    logic x1, x2, x3, x4, y1, y2, y3, y4, z, p1, p2, p3, p4;
    x1 = x[3]; x2 = x[2]; x4 = x[1]; x3 = x[0];
    y1 = y[3]; y2 = y[2]; y4 = y[1]; y3 = y[0];
    z  = (x1 & y4) ^ (x4 & y1) ^ (x2 & y3) ^ (x3 & y2);
    p1 = (x2 & y4) ^ (x4 & y2) ^ (x3 & y3) ^ z;
    p2 = (x1 & y1) ^ (x3 & y4) ^ (x4 & y3) ^ z;
    p3 = (x1 & y2) ^ (x2 & y1) ^ (x4 & y4) ^ z;
    p4 = (x1 & y3) ^ (x3 & y1) ^ (x2 & y2) ^ z;
    return {p1, p2, p4, p3};
  endfunction

  logic              s1_vld_q, s1_vld_d;
  logic [BYTE_W-1:0] s1_data_q, s1_data_d;
  logic              s2_vld_q, s2_vld_d;
  front_t            s2_q, s2_d;
`ifdef GF_INV_8_FRONT_SKID_EN
  logic              skid_vld_q, skid_vld_d;
  logic [BYTE_W-1:0] skid_data_q, skid_data_d;
  logic              in_acc;
`endif

  logic              s2_accept, src_vld, src_ready, src_take;
  logic              fe_vld, fe_room, fe_adv, s1_load;
  logic [BYTE_W-1:0] src_data, fe_data;
  logic [NIB_W-1:0]  fe_a, fe_b, fe_c;

  // Handshake chain, stage loads and the c arithmetic.
  always_comb begin
    s2_accept = !s2_vld_q || out_ready;

`ifdef GF_INV_8_FRONT_SKID_EN
    // A held skid byte is older than in_data, so it goes first.
    src_vld  = skid_vld_q || in_valid;
    src_data = skid_vld_q ? skid_data_q : in_data;
`else
    src_vld  = in_valid;
    src_data = in_data;
`endif

    // fe_* is whatever feeds the arithmetic: S1 or the raw source.
    if (REG_INPUT != 0) begin
      fe_vld  = s1_vld_q;
      fe_data = s1_data_q;
      fe_room = !s1_vld_q || s2_accept;
    end else begin
      fe_vld  = src_vld;
      fe_data = src_data;
      fe_room = s2_accept;
    end

    src_ready = !flush && fe_room;
    src_take  = src_vld && src_ready;
    fe_adv    = fe_vld && s2_accept && !flush;
    s1_load   = (REG_INPUT != 0) && src_take;

    s1_vld_d  = s1_vld_q;
    s1_data_d = s1_data_q;
    if (flush)        s1_vld_d = 1'b0;
    else if (s1_load) s1_vld_d = 1'b1;
    else if (fe_adv)  s1_vld_d = 1'b0;
    if (s1_load) s1_data_d = src_data;

    fe_a = fe_data[BYTE_W-1:NIB_W];
    fe_b = fe_data[NIB_W-1:0];
    fe_c = gf_sq_scl_4(fe_a ^ fe_b) ^ gf_muls_4(fe_a, fe_b);

    s2_vld_d = s2_vld_q;
    s2_d     = s2_q;
    if (flush)                      s2_vld_d = 1'b0;
    else if (fe_adv)                s2_vld_d = 1'b1;
    else if (s2_vld_q && out_ready) s2_vld_d = 1'b0;
    if (fe_adv) s2_d = '{a: fe_a, b: fe_b, c: fe_c};

`ifdef GF_INV_8_FRONT_SKID_EN
    in_ready    = !skid_vld_q && !flush;
    in_acc      = in_valid && in_ready;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      if (src_ready) skid_vld_d = 1'b0;
    end else if (in_acc && !src_ready) begin
      skid_vld_d  = 1'b1;
      skid_data_d = in_data;
    end
`else
    in_ready = src_ready;
`endif
  end

  // Pipeline state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q    <= 1'b0;
      s1_data_q   <= '0;
      s2_vld_q    <= 1'b0;
      s2_q        <= '0;
`ifdef GF_INV_8_FRONT_SKID_EN
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
`endif
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_data_q   <= s1_data_d;
      s2_vld_q    <= s2_vld_d;
      s2_q        <= s2_d;
`ifdef GF_INV_8_FRONT_SKID_EN
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
`endif
    end
  end

  assign out_valid = s2_vld_q;
  assign out_a     = s2_q.a;
  assign out_b     = s2_q.b;
  assign out_c     = s2_q.c;

endmodule

// File: tb/tb_gf_inv_8_front.sv
// Self-checking bench for gf_inv_8_front (default build, REG_INPUT = 1).
module tb_gf_inv_8_front;

  localparam int unsigned REG_INPUT = 1;
  localparam int LAT = (REG_INPUT != 0) ? 2 : 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_a, out_b, out_c;

  gf_inv_8_front #(.REG_INPUT(REG_INPUT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_c(out_c)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
  } exp_t;

  typedef struct {
    logic [7:0] din;
    logic [3:0] ea;
    logic [3:0] eb;
    logic [3:0] ec;
  } vec_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    n_out = 0;
  int    mark_n = 0;
  int    mark_first = 0;
  int    last_out_cyc = 0;
  bit    last_xfer = 0;
  bit    hold_pend = 0;
  logic [11:0] hold_val = '0;

  // Reference multiply: coordinates are indexed by exponent of B (B^5 = 1).
  // The product is a convolution mod 5, and the exponent-0 term is the unit.
  function automatic logic [3:0] ref_mul(input logic [3:0] x, input logic [3:0] y);
    int ex [4];
    logic [4:0] acc;
    logic [3:0] r;
    ex  = '{3, 4, 2, 1};
    acc = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (x[i] && y[j]) acc[(ex[i] + ex[j]) % 5] = ~acc[(ex[i] + ex[j]) % 5];
    for (int i = 0; i < 4; i++) r[i] = acc[ex[i]] ^ acc[0];
    return r;
  endfunction

  function automatic exp_t model(input logic [7:0] d);
    exp_t e;
    logic [3:0] s;
    e.a = d[7:4];
    e.b = d[3:0];
    s   = e.a ^ e.b;
    e.c = ref_mul(4'h8, ref_mul(s, s)) ^ ref_mul(e.a, e.b);
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Samples on the falling edge, then advances to just after the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    last_xfer = 1'b0;
    if (rst_n) begin
      if (hold_pend)
        chk("hold_stable", int'({out_valid, out_a, out_b, out_c}), int'({1'b1, hold_val}));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: got output 0x%03h, expected no output",
                   {out_a, out_b, out_c});
        end else begin
          e = sb.pop_front();
          chk("sb_data", int'({out_a, out_b, out_c}), int'(e));
        end
        if (n_out == mark_n) mark_first = cyc;
        last_out_cyc = cyc;
        n_out++;
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) begin
        sb.push_back(model(in_data));
        last_xfer = 1'b1;
      end
      hold_pend = out_valid && !out_ready && !flush;
      hold_val  = {out_a, out_b, out_c};
    end else begin
      hold_pend = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Offers one byte, then counts cycles until out_valid (transfer cycle = 1).
  task automatic send_measure(input logic [7:0] d, output int lat);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    chk("send_accept", int'(last_xfer), 1);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (sb.size() != 0 && g < 50) begin
      tick();
      g++;
    end
    tick();
    chk("drain_empty", sb.size(), 0);
  endtask

  // Streams n bytes from base, with out_ready low for stall_len cycles.
  task automatic stream(input int n, input logic [7:0] base, input int stall_at,
                        input int stall_len, output int drops);
    int sent, i;
    sent  = 0;
    i     = 0;
    drops = 0;
    while (sent < n && i < 4 * n + 50) begin
      out_ready = !(i >= stall_at && i < stall_at + stall_len);
      in_valid  = 1'b1;
      in_data   = base + 8'(sent);
      tick();
      if (last_xfer) sent++;
      else drops++;
      i++;
    end
    in_valid = 1'b0;
    chk("stream_sent", sent, n);
  endtask

  initial begin
    vec_t vecs [8];
    int   lat, drops, accepts, base_n;
    exp_t e;

    vecs[0] = '{8'h00, 4'h0, 4'h0, 4'h0};
    vecs[1] = '{8'h11, 4'h1, 4'h1, 4'h8};
    vecs[2] = '{8'hFF, 4'hF, 4'hF, 4'hF};
    vecs[3] = '{8'h10, 4'h1, 4'h0, 4'h4};
    vecs[4] = '{8'h01, 4'h0, 4'h1, 4'h4};
    vecs[5] = '{8'h80, 4'h8, 4'h0, 4'h1};
    vecs[6] = '{8'h88, 4'h8, 4'h8, 4'h4};
    vecs[7] = '{8'h84, 4'h8, 4'h4, 4'hF};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_abc", int'({out_a, out_b, out_c}), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();

    // Single-byte vectors: latency and values.
    for (int k = 0; k < 8; k++) begin
      send_measure(vecs[k].din, lat);
      chk($sformatf("vec%0d_lat", k), lat, LAT);
      chk($sformatf("vec%0d_a", k), int'(out_a), int'(vecs[k].ea));
      chk($sformatf("vec%0d_b", k), int'(out_b), int'(vecs[k].eb));
      chk($sformatf("vec%0d_c", k), int'(out_c), int'(vecs[k].ec));
    end
    drain();

    // Full-rate stream 00..FF with no gaps.
    mark_n = n_out;
    stream(256, 8'h00, 100000, 0, drops);
    chk("stream_drops", drops, 0);
    drain();
    chk("stream_count", n_out - mark_n, 256);
    chk("stream_span", last_out_cyc - mark_first + 1, 256);

    // Backpressure from an empty pipe: two accepts, then in_ready falls.
    out_ready = 1'b0;
    accepts   = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(accepts);
      tick();
      if (last_xfer) accepts++;
    end
    chk("bp_accepts", accepts, 2);
    chk("bp_in_ready", int'(in_ready), 0);
    in_valid = 1'b0;
    drain();

    // Mid-stream stall of five cycles.
    base_n = n_out;
    stream(40, 8'h37, 10, 5, drops);
    chk("stall_drops_seen", int'(drops > 0), 1);
    drain();
    chk("stall_count", n_out - base_n, 40);

    // Flush with two bytes in flight and a concurrent offer.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    tick();
    in_data   = 8'hC3;
    tick();
    chk("flush_pre_valid", int'(out_valid), 1);
    out_ready = 1'b0;
    flush     = 1'b1;
    in_data   = 8'h77;
    #1;
    chk("flush_in_ready", int'(in_ready), 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", int'(out_valid), 0);
    out_ready = 1'b1;
    tick();
    chk("flush_no_ghost", int'(out_valid), 0);
    send_measure(8'h3C, lat);
    e = model(8'h3C);
    chk("flush_next_lat", lat, LAT);
    chk("flush_next_abc", int'({out_a, out_b, out_c}), int'(e));
    drain();

    // Asynchronous reset with the pipe full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h96;
    tick();
    in_data   = 8'h2B;
    tick();
    chk("arst_pre_valid", int'(out_valid), 1);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_abc", int'({out_a, out_b, out_c}), 0);
    sb.delete();
    hold_pend = 1'b0;
    tick();
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("arst_idle_valid", int'(out_valid), 0);
    send_measure(8'hE7, lat);
    e = model(8'hE7);
    chk("arst_first_lat", lat, LAT);
    chk("arst_first_abc", int'({out_a, out_b, out_c}), int'(e));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gf_inv_8_front.md
Name: gf_inv_8_front

Overview:
- Upstream stage of the pipelined GF(2^8) inverter in the composite-field S-box.
- Takes one byte in the GF(2^8)/GF(2^4) normal basis and splits it into high nibble a and low nibble b.
- Computes the 4-bit value c = ν·(a⊕b)^2 ⊕ a·b, which feeds gf_inv_4. Arithmetic uses the existing square-scale and multiply helpers: gf_sq_scl_4 and gf_muls_4.
- Registers {a, b, c} behind a valid/ready handshake. The downstream multiply stage consumes a and b alongside the GF(2^4) inverse.

Parameters:
- REG_INPUT, 1, 1 = input register stage before the arithmetic (latency 2); 0 = arithmetic directly on in_data (latency 1).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all pipeline valids
- in_valid  input  1  in_data valid
- in_ready  output  1  stage accepts in_data this cycle
- in_data  input  8  byte, normal basis; [7:4]=a, [3:0]=b
- out_valid  output  1  out_a/out_b/out_c valid
- out_ready  input  1  downstream accepts this cycle
- out_a  output  4  registered high nibble a
- out_b  output  4  registered low nibble b
- out_c  output  4  registered ν·(a⊕b)^2 ⊕ a·b, to gf_inv_4 input

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all valid flags 0; out_a, out_b, out_c = 4'h0; in_ready = 1 when the optional feature is off.
- Transfer rule: a transfer occurs on a rising edge with valid && ready.
- Source rules: data is held stable while valid && !ready, and valid is never withdrawn before the transfer.
- Arithmetic (combinational, no carries, all XOR/AND in GF(2^4) normal basis):
  - s = a⊕b
  - c = gf_sq_scl_4(s) ⊕ gf_muls_4(a, b)
  - Widths fixed at 4 bits.
- Pipeline, REG_INPUT=1: stage S1 holds the byte, stage S2 holds {a, b, c}.
  - Latency: 2 cycles from input transfer to out_valid with out_ready held high.
- Pipeline, REG_INPUT=0: only S2 exists. Latency is 1 cycle.
- Per-stage valid bit vld_k:
  - Stage k loads when its upstream transfers and (!vld_k or stage k drains this cycle).
  - Full throughput is 1 byte per cycle.
- Ready chain: in_ready = !vld_S1 || (S1 advances into S2 this cycle), where S2 accepts when !vld_S2 || out_ready.
- Combinational path: without the optional feature, in_ready is combinational from out_ready through the valid chain.
- Backpressure: out_ready=0 freezes S2. S1 fills behind it, then in_ready=0. No data loss, no duplication.
- Simultaneous fill and drain: each full stage may drain and reload in the same cycle.
- flush=1:
  - All valids clear on the next edge; data registers keep their values.
  - in_ready=0 during the flush cycle, and an input offered that cycle is not accepted.
  - Flush has priority over a simultaneous transfer.
- Reset mid-operation: in-flight bytes are dropped. The first post-reset output is the first byte accepted after rst_n deasserts.
- Data registers update only on load, which keeps toggling low when idle.

Optional Feature:
- Macro GF_INV_8_FRONT_SKID_EN.
- Defined: adds a one-entry skid buffer at the input.
  - in_ready is a register output: in_ready = !skid_valid. No combinational path from out_ready to in_ready.
  - While in_ready=1 and the pipeline stalls, one extra byte is captured into the skid buffer.
  - The skid buffer drains into S1 before new input.
  - Latency is unchanged when the skid buffer is empty.
  - Reset/flush also clear skid_valid.
- Undefined: no skid logic; in_ready is combinational as above.

Test Plan:
- Zero byte: reset, in_data=8'h00 with out_ready=1 -> out_valid at cycle 2 (REG_INPUT=1) with a=0, b=0, c=0.
- Equal nibbles: in_data=8'h11 -> out_a=4'h1, out_b=4'h1, out_c=4'h8 (a⊕b=0, so c=a^2 = nibble rotation); in_data=8'hFF -> a=F, b=F, c=F.
- Streaming: 256 bytes 8'h00..8'hFF back-to-back with out_ready=1 -> 256 outputs in order, one per cycle, each matching the reference-model c; no bubbles after the initial latency.
- Backpressure: stream with out_ready=0 for 5 cycles mid-stream -> in_ready drops after 2 accepts (3 with skid), outputs held stable, order preserved, no loss or duplicates.
- Flush with concurrent input: flush pulse with 2 bytes in flight and in_valid=1 -> out_valid=0 next cycle, concurrent byte not accepted, next byte emerges with normal latency.
- Async reset: assert rst_n=0 mid-clock with pipeline full -> out_valid=0 and outputs 4'h0 immediately, without a clock edge; after release the first output is the first newly accepted byte.
